pipelined_control_unit: RTL and testbench

Decode-and-carry control block for the 5-stage pipelined RISC-V core. Decodes the instruction held in the Decode stage into a control bundle, then carries that bundle through the ID/EX, EX/MEM and MEM/WB registers with flush support. It resolves branch and jump redirection in Execute, and flags unsupported opcodes. It replaces the single-cycle control path and feeds the datapath and hazard unit directly.

---
 rtl/pipelined_control_unit.sv | 131 +++++++++++++
 tb/tb_pipelined_control_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: RV32 decode plus ID/EX, EX/MEM, MEM/WB control pipeline with flush and E-stage redirect.
// Optional feature macro PCU_BRANCH_EXT_EN: when defined, blt/bge/bltu/bgeu are legal; otherwise only beq/bne.
module pipelined_control_unit #(
  parameter int ALU_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      InstrD,
  input  logic             FlushE,
  input  logic             ZeroE,
  input  logic             LtE,
  input  logic             LtuE,
  output logic [1:0]       ImmSrcD,
  output logic             IllegalD,
  output logic             RegWriteE,
  output logic             RegWriteM,
  output logic             RegWriteW,
  output logic [1:0]       ResultSrcE,
  output logic [1:0]       ResultSrcW,
  output logic             MemWriteM,
  output logic             ALUSrcE,
  output logic [ALU_W-1:0] ALUControlE,
  output logic             PCSrcE
);
  localparam int IDEX_W = 10 + ALU_W;
  logic [6:0]        op;
  logic [2:0]        f3;
  logic              f7b5;
  logic [3:0]        arith;
  logic              arith_ext;
  logic              br_bad;
  logic              reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d, illegal_d;
  logic [1:0]        result_src_d, imm_src_d;
  logic [3:0]        alu4_d;
  logic [IDEX_W-1:0] id_ex_d, id_ex_q;
  logic [3:0]        ex_mem_q;
  logic [2:0]        mem_wb_q;
  logic              mem_write_e, jump_e, branch_e, taken;
  logic [2:0]        funct3_e;
  logic              unused_instr;
  assign op   = InstrD[6:0];
  assign f3   = InstrD[14:12];
  assign f7b5 = InstrD[30];
  assign unused_instr = ^{InstrD[31], InstrD[29:15], InstrD[11:7]};
`ifdef PCU_BRANCH_EXT_EN
  assign br_bad = (f3[2:1] == 2'b01);
`else
  assign br_bad = (f3[2:1] == 2'b01) | f3[2];
`endif
  assign arith_ext = (f3 == 3'b001) | (f3 == 3'b011) | (f3[2:1] == 2'b10);
  // ALU operation for R-type and I-ALU; sub only exists as R-type with funct7b5
  always_comb begin
    arith = 4'b0010;
    case (f3)
      3'b000:  arith = (op[5] & f7b5) ? 4'b0001 : 4'b0000;
      3'b001:  arith = 4'b0110;
      3'b010:  arith = 4'b0101;
      3'b011:  arith = 4'b1001;
      3'b100:  arith = 4'b0100;
      3'b101:  arith = f7b5 ? 4'b1000 : 4'b0111;
      3'b110:  arith = 4'b0011;
      default: arith = 4'b0010;
    endcase
  end
  // Main decoder; anything illegal collapses to an all-zero bundle
  always_comb begin
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    jump_d       = 1'b0;
    branch_d     = 1'b0;
    alu_src_d    = 1'b0;
    illegal_d    = 1'b0;
    result_src_d = 2'b00;
    imm_src_d    = 2'b00;
    alu4_d       = 4'b0000;
    case (op)
      7'b0000011: begin reg_write_d = 1'b1; alu_src_d = 1'b1; result_src_d = 2'b01; end
      7'b0100011: begin mem_write_d = 1'b1; alu_src_d = 1'b1; imm_src_d = 2'b01; end
      7'b0110011, 7'b0010011: begin
        reg_write_d = 1'b1;
        alu_src_d   = ~op[5];
        alu4_d      = arith;
        illegal_d   = arith_ext & (ALU_W == 3);
      end
      7'b1100011: begin branch_d = 1'b1; imm_src_d = 2'b10; alu4_d = 4'b0001; illegal_d = br_bad; end
      7'b1101111: begin jump_d = 1'b1; reg_write_d = 1'b1; imm_src_d = 2'b11; result_src_d = 2'b10; end
      default:    illegal_d = 1'b1;
    endcase
    if (illegal_d) begin
      reg_write_d  = 1'b0;
      mem_write_d  = 1'b0;
      jump_d       = 1'b0;
      branch_d     = 1'b0;
      alu_src_d    = 1'b0;
      result_src_d = 2'b00;
      imm_src_d    = 2'b00;
      alu4_d       = 4'b0000;
    end
  end
  assign ImmSrcD  = imm_src_d;
  assign IllegalD = illegal_d;
  assign id_ex_d  = {reg_write_d, result_src_d, mem_write_d, jump_d, branch_d,
                     illegal_d ? 3'b000 : f3, alu4_d[ALU_W-1:0], alu_src_d};
  // ID/EX: a flush loads a bubble so nothing in D reaches E
  always_ff @(posedge clk or posedge reset)
    if (reset) id_ex_q <= '0;
    else       id_ex_q <= FlushE ? '0 : id_ex_d;
  assign {RegWriteE, ResultSrcE, mem_write_e, jump_e, branch_e, funct3_e, ALUControlE, ALUSrcE} = id_ex_q;
  // EX/MEM and MEM/WB keep advancing regardless of flush
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      ex_mem_q <= {RegWriteE, ResultSrcE, mem_write_e};
      mem_wb_q <= ex_mem_q[3:1];
    end
  assign RegWriteM  = ex_mem_q[3];
  assign MemWriteM  = ex_mem_q[0];
  assign RegWriteW  = mem_wb_q[2];
  assign ResultSrcW = mem_wb_q[1:0];
`ifdef PCU_BRANCH_EXT_EN
  assign taken = funct3_e[2] ? ((funct3_e[1] ? LtuE : LtE) ^ funct3_e[0])
                             : (~funct3_e[1] & (ZeroE ^ funct3_e[0]));
`else
  logic unused_lt;
  assign unused_lt = LtE ^ LtuE;
  assign taken = ~funct3_e[2] & ~funct3_e[1] & (ZeroE ^ funct3_e[0]);
`endif
  assign PCSrcE = jump_e | (branch_e & taken);
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit: directed checks of decode, pipeline carry, flush, redirect and async reset.
module tb_pipelined_control_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] InstrD = 32'h0;
  logic        FlushE = 1'b0, ZeroE = 1'b0, LtE = 1'b0, LtuE = 1'b0;
  logic [1:0]  ImmSrcD, ResultSrcE, ResultSrcW;
  logic        IllegalD, RegWriteE, RegWriteM, RegWriteW, MemWriteM, ALUSrcE, PCSrcE;
  logic [2:0]  ALUControlE;
  int checks = 0, errors = 0;

  pipelined_control_unit dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
    .ImmSrcD(ImmSrcD), .IllegalD(IllegalD), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .ResultSrcW(ResultSrcW), .MemWriteM(MemWriteM),
    .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .PCSrcE(PCSrcE)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    checks++; if ({RegWriteE, RegWriteM, RegWriteW, ResultSrcE, ResultSrcW, MemWriteM, ALUSrcE, PCSrcE} !== 10'b0)
      begin errors++; $display("FAIL reset_outs: got %b expected 0", {RegWriteE, RegWriteM, RegWriteW, ResultSrcE, ResultSrcW, MemWriteM, ALUSrcE, PCSrcE}); end
    checks++; if (ALUControlE !== 3'b000) begin errors++; $display("FAIL reset_alu: got %b expected 000", ALUControlE); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_lw;
    InstrD = 32'h00002083;
    #1;
    checks++; if ({IllegalD, ImmSrcD} !== 3'b000) begin errors++; $display("FAIL lw_decode: got %b expected 000", {IllegalD, ImmSrcD}); end
    tick();
    InstrD = 32'h0;
    checks++; if ({RegWriteE, ResultSrcE, ALUSrcE, ALUControlE} !== 7'b1011_000) begin errors++; $display("FAIL lw_e: got %b expected 1011000", {RegWriteE, ResultSrcE, ALUSrcE, ALUControlE}); end
    tick();
    checks++; if ({RegWriteM, MemWriteM} !== 2'b10) begin errors++; $display("FAIL lw_m: got %b expected 10", {RegWriteM, MemWriteM}); end
    tick();
    checks++; if ({RegWriteW, ResultSrcW} !== 3'b101) begin errors++; $display("FAIL lw_w: got %b expected 101", {RegWriteW, ResultSrcW}); end
  endtask

  task automatic test_alu;
    logic [31:0] ins [6] = '{32'h40000033, 32'h00000033, 32'h00006033, 32'h00007033, 32'h00002033, 32'h00000013};
    logic [3:0]  exp [6] = '{4'b0001, 4'b0000, 4'b0011, 4'b0010, 4'b0101, 4'b1000};
    InstrD = ins[0];
    for (int i = 0; i < 6; i++) begin
      tick();
      InstrD = (i < 5) ? ins[i+1] : 32'h00004033;
      checks++; if ({ALUSrcE, ALUControlE} !== exp[i] || RegWriteE !== 1'b1)
        begin errors++; $display("FAIL alu_%0d: got src/alu %b rw %b expected %b rw 1", i, {ALUSrcE, ALUControlE}, RegWriteE, exp[i]); end
    end
    #1;
    checks++; if (IllegalD !== 1'b1) begin errors++; $display("FAIL xor_illegal: got %b expected 1", IllegalD); end
    tick();
    InstrD = 32'h0;
    checks++; if ({RegWriteE, ALUControlE} !== 4'b0) begin errors++; $display("FAIL xor_e: got %b expected 0000", {RegWriteE, ALUControlE}); end
    tick();
  endtask

  task automatic test_branch;
    InstrD = 32'h00000063;
    #1;
    checks++; if ({IllegalD, ImmSrcD} !== 3'b010) begin errors++; $display("FAIL beq_decode: got %b expected 010", {IllegalD, ImmSrcD}); end
    tick();
    InstrD = 32'h00001063;
    ZeroE = 1'b1;
    #1;
    checks++; if ({PCSrcE, RegWriteE, ALUControlE} !== 5'b10001) begin errors++; $display("FAIL beq_taken: got %b expected 10001", {PCSrcE, RegWriteE, ALUControlE}); end
    ZeroE = 1'b0;
    #1;
    checks++; if (PCSrcE !== 1'b0) begin errors++; $display("FAIL beq_not_taken: got %b expected 0", PCSrcE); end
    tick();
    InstrD = 32'h00000063;
    checks++; if (PCSrcE !== 1'b1) begin errors++; $display("FAIL bne_taken: got %b expected 1", PCSrcE); end
    tick();
    InstrD = 32'h0;
    ZeroE = 1'b1;
    FlushE = 1'b1;
    #1;
    checks++; if (PCSrcE !== 1'b1) begin errors++; $display("FAIL flush_keeps_e: got %b expected 1", PCSrcE); end
    tick();
    FlushE = 1'b0;
    checks++; if (PCSrcE !== 1'b0) begin errors++; $display("FAIL bubble_no_redirect: got %b expected 0", PCSrcE); end
    ZeroE = 1'b0;
  endtask

  task automatic test_flush;
    InstrD = 32'h00102023;
    #1;
    checks++; if (ImmSrcD !== 2'b01) begin errors++; $display("FAIL sw_imm: got %b expected 01", ImmSrcD); end
    FlushE = 1'b1;
    tick();
    FlushE = 1'b0;
    InstrD = 32'h0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({RegWriteE, ResultSrcE, ALUSrcE, RegWriteM, MemWriteM, RegWriteW, ResultSrcW} !== 10'b0)
        begin errors++; $display("FAIL flush_cycle_%0d: got %b expected 0", i, {RegWriteE, ResultSrcE, ALUSrcE, RegWriteM, MemWriteM, RegWriteW, ResultSrcW}); end
      tick();
    end
    InstrD = 32'h00102023;
    tick();
    InstrD = 32'h0;
    checks++; if ({RegWriteE, ALUSrcE} !== 2'b01) begin errors++; $display("FAIL sw_e: got %b expected 01", {RegWriteE, ALUSrcE}); end
    tick();
    checks++; if ({MemWriteM, RegWriteM} !== 2'b10) begin errors++; $display("FAIL sw_m: got %b expected 10", {MemWriteM, RegWriteM}); end
    tick();
  endtask

  task automatic test_illegal;
    logic [31:0] ins [3] = '{32'h0000007F, 32'h00004063, 32'h00002063};
    LtE = 1'b1;
    LtuE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      InstrD = ins[i];
      #1;
      checks++; if ({IllegalD, ImmSrcD} !== 3'b100) begin errors++; $display("FAIL illegal_d_%0d: got %b expected 100", i, {IllegalD, ImmSrcD}); end
      tick();
      checks++; if ({PCSrcE, RegWriteE, ResultSrcE, ALUSrcE, ALUControlE} !== 8'b0)
        begin errors++; $display("FAIL illegal_e_%0d: got %b expected 0", i, {PCSrcE, RegWriteE, ResultSrcE, ALUSrcE, ALUControlE}); end
    end
    InstrD = 32'h0;
    LtE = 1'b0;
    LtuE = 1'b0;
    tick();
  endtask

  task automatic test_jal_reset;
    InstrD = 32'h0000006F;
    #1;
    checks++; if (ImmSrcD !== 2'b11) begin errors++; $display("FAIL jal_imm: got %b expected 11", ImmSrcD); end
    tick();
    InstrD = 32'h00002083;
    checks++; if ({PCSrcE, RegWriteE, ResultSrcE} !== 4'b1110) begin errors++; $display("FAIL jal_e: got %b expected 1110", {PCSrcE, RegWriteE, ResultSrcE}); end
    #1;
    reset = 1'b1;
    #1;
    checks++; if ({PCSrcE, RegWriteE, RegWriteM, RegWriteW} !== 4'b0) begin errors++; $display("FAIL async_reset: got %b expected 0000", {PCSrcE, RegWriteE, RegWriteM, RegWriteW}); end
    #1;
    reset = 1'b0;
    tick();
    InstrD = 32'h0;
    checks++; if ({RegWriteE, ResultSrcE, RegWriteM} !== 4'b1010) begin errors++; $display("FAIL post_reset: got %b expected 1010", {RegWriteE, ResultSrcE, RegWriteM}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_alu();
    test_branch();
    test_flush();
    test_illegal();
    test_jal_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
